// File: rtl/prv_trap_sequencer.sv
// Trap/return sequencer: captures the highest-priority exception or interrupt (or an mret),
// waits for the pipeline to drain, then issues a one-cycle PC redirect.
module prv_trap_sequencer #(
    parameter int NUM_EXC   = 16,
    parameter int NUM_INT   = 12,
    parameter int DRAIN_MAX = 15
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_EXC-1:0] exc_valid,
    input  logic [31:0]        exc_epc,
    input  logic [31:0]        exc_badaddr,
    input  logic [NUM_INT-1:0] int_pending,
    input  logic [NUM_INT-1:0] int_enable,
    input  logic               mie,
    input  logic               mret,
    input  logic               pipe_clear,
    input  logic [31:0]        xtvec,
    input  logic [31:0]        xepc_r,
    output logic               insert_pc,
    output logic [31:0]        priv_pc,
    output logic               intr,
    output logic               trap_commit,
    output logic [31:0]        cause,
    output logic [31:0]        epc,
    output logic [31:0]        badaddr,
    output logic               busy,
    output logic               drain_timeout,
    output logic [1:0]         state_dbg
);

    localparam int SRC_MAX = (NUM_EXC > NUM_INT) ? NUM_EXC : NUM_INT;
    localparam int IDX_W   = (SRC_MAX > 1) ? $clog2(SRC_MAX) : 1;
    localparam int CNT_W   = (DRAIN_MAX > 0) ? $clog2(DRAIN_MAX + 1) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    // Handshake: requests are level inputs sampled only while IDLE; insert_pc is a
    // single-cycle strobe with no back-pressure, priv_pc is meaningful only alongside it.

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   cause_idx;
    logic               is_ret;

    logic               exc_hit, int_hit;
    logic [IDX_W-1:0]   exc_idx, int_idx;
    logic [NUM_INT-1:0] int_req;
    logic               drain_done;

    assign int_req = int_pending & int_enable & {NUM_INT{mie}};

    // Lowest set index wins: scan downward so the last assignment is the lowest.
    always_comb begin
        exc_hit = 1'b0;
        exc_idx = '0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (exc_valid[i]) begin
                exc_hit = 1'b1;
                exc_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        int_hit = 1'b0;
        int_idx = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (int_req[i]) begin
                int_hit = 1'b1;
                int_idx = IDX_W'(i);
            end
        end
    end

    assign drain_done = pipe_clear || (cnt == CNT_W'(DRAIN_MAX));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        insert_pc   = 1'b0;
        trap_commit = 1'b0;
        priv_pc     = 32'd0;
        case (state)
            IDLE: begin
                if (exc_hit || int_hit || mret) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_next = REDIRECT;
                end
            end
            REDIRECT: begin
                state_next = IDLE;
                insert_pc  = 1'b1;
                if (is_ret) begin
                    priv_pc = xepc_r;
                end else begin
                    trap_commit = 1'b1;
                    // Only mode 1 vectors; reserved modes fall back to the direct base.
                    priv_pc = {xtvec[31:2], 2'b00};
                    if (intr && (xtvec[1:0] == 2'b01)) begin
                        priv_pc = {xtvec[31:2], 2'b00} + (32'(cause_idx) << 2);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt           <= '0;
            cause_idx     <= '0;
            intr          <= 1'b0;
            epc           <= 32'd0;
            badaddr       <= 32'd0;
            is_ret        <= 1'b0;
            drain_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (exc_hit) begin
                        cause_idx <= exc_idx;
                        intr      <= 1'b0;
                        epc       <= exc_epc;
                        badaddr   <= exc_badaddr;
                        is_ret    <= 1'b0;
                    end else if (int_hit) begin
                        cause_idx <= int_idx;
                        intr      <= 1'b1;
                        epc       <= exc_epc;
                        badaddr   <= 32'd0;
                        is_ret    <= 1'b0;
                    end else if (mret) begin
                        // A return leaves the captured trap record untouched.
                        is_ret <= 1'b1;
                    end
                end
                DRAIN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (!pipe_clear && (cnt == CNT_W'(DRAIN_MAX))) begin
                        drain_timeout <= 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    assign cause     = {intr, 31'(cause_idx)};
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Bench for prv_trap_sequencer: directed trap/return/timeout/reset scenarios, an abstract
// timing model checked every cycle, and literal expectations for the key scenarios.
module tb_prv_trap_sequencer;

    localparam int NUM_EXC   = 16;
    localparam int NUM_INT   = 12;
    localparam int DRAIN_MAX = 15;

    logic               CLK;
    logic               RST;
    logic [NUM_EXC-1:0] exc_valid;
    logic [31:0]        exc_epc;
    logic [31:0]        exc_badaddr;
    logic [NUM_INT-1:0] int_pending;
    logic [NUM_INT-1:0] int_enable;
    logic               mie;
    logic               mret;
    logic               pipe_clear;
    logic [31:0]        xtvec;
    logic [31:0]        xepc_r;
    logic               insert_pc;
    logic [31:0]        priv_pc;
    logic               intr;
    logic               trap_commit;
    logic [31:0]        cause;
    logic [31:0]        epc;
    logic [31:0]        badaddr;
    logic               busy;
    logic               drain_timeout;
    logic [1:0]         state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    prv_trap_sequencer #(
        .NUM_EXC  (NUM_EXC),
        .NUM_INT  (NUM_INT),
        .DRAIN_MAX(DRAIN_MAX)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .exc_valid    (exc_valid),
        .exc_epc      (exc_epc),
        .exc_badaddr  (exc_badaddr),
        .int_pending  (int_pending),
        .int_enable   (int_enable),
        .mie          (mie),
        .mret         (mret),
        .pipe_clear   (pipe_clear),
        .xtvec        (xtvec),
        .xepc_r       (xepc_r),
        .insert_pc    (insert_pc),
        .priv_pc      (priv_pc),
        .intr         (intr),
        .trap_commit  (trap_commit),
        .cause        (cause),
        .epc          (epc),
        .badaddr      (badaddr),
        .busy         (busy),
        .drain_timeout(drain_timeout),
        .state_dbg    (state_dbg)
    );

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_set(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Behavioural model: m_wait counts cycles spent waiting for the drain (-1 = no
    // request in flight); m_redir marks the single redirect cycle.
    int          m_wait = -1;
    bit          m_redir = 1'b0;
    bit          m_ret = 1'b0;
    int          m_code = 0;
    bit          m_intr = 1'b0;
    logic [31:0] m_epc = '0;
    logic [31:0] m_bad = '0;
    bit          m_timeout = 1'b0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_wait = -1; m_redir = 0; m_ret = 0; m_code = 0; m_intr = 0;
            m_epc = '0; m_bad = '0; m_timeout = 0;
        end else if (m_redir) begin
            m_redir = 0;
        end else if (m_wait >= 0) begin
            if (pipe_clear || m_wait == DRAIN_MAX) begin
                if (!pipe_clear) m_timeout = 1;
                m_redir = 1;
                m_wait  = -1;
            end else begin
                m_wait++;
            end
        end else begin
            int e, q;
            e = lowest_set(32'(exc_valid), NUM_EXC);
            q = mie ? lowest_set(32'(int_pending & int_enable), NUM_INT) : -1;
            if (e >= 0) begin
                m_code = e; m_intr = 0; m_epc = exc_epc; m_bad = exc_badaddr;
                m_ret = 0; m_wait = 0;
            end else if (q >= 0) begin
                m_code = q; m_intr = 1; m_epc = exc_epc; m_bad = 32'd0;
                m_ret = 0; m_wait = 0;
            end else if (mret) begin
                m_ret = 1; m_wait = 0;
            end
        end
    end

    // Compare process: DUT against model one time unit after every falling edge.
    initial begin
        forever begin
            logic [31:0] exp_pc;
            @(negedge CLK);
            #1;
            exp_pc = 32'd0;
            if (m_redir) begin
                if (m_ret) begin
                    exp_pc = xepc_r;
                end else begin
                    exp_pc = xtvec & 32'hFFFF_FFFC;
                    if (m_intr && xtvec[1:0] == 2'd1) exp_pc = exp_pc + 32'(4 * m_code);
                end
            end
            check("model.busy", 32'(busy), 32'(m_redir || m_wait >= 0));
            check("model.insert_pc", 32'(insert_pc), 32'(m_redir));
            check("model.trap_commit", 32'(trap_commit), 32'(m_redir && !m_ret));
            check("model.priv_pc", priv_pc, exp_pc);
            check("model.cause", cause, (m_intr ? 32'h8000_0000 : 32'h0) + 32'(m_code));
            check("model.intr", 32'(intr), 32'(m_intr));
            check("model.epc", epc, m_epc);
            check("model.badaddr", badaddr, m_bad);
            check("model.drain_timeout", 32'(drain_timeout), 32'(m_timeout));
        end
    end

    // Driver: present a request for one cycle, then withdraw it.
    task automatic send(input logic [NUM_EXC-1:0] exc, input logic [31:0] pc,
                        input logic [31:0] bad, input logic [NUM_INT-1:0] ip,
                        input logic ret);
        @(negedge CLK);
        exc_valid   = exc;
        exc_epc     = pc;
        exc_badaddr = bad;
        int_pending = ip;
        mret        = ret;
        @(negedge CLK);
        exc_valid   = '0;
        int_pending = '0;
        mret        = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        exc_valid = '0; exc_epc = '0; exc_badaddr = '0;
        int_pending = '0; int_enable = '0; mie = 1'b0; mret = 1'b0;
        pipe_clear = 1'b1; xtvec = 32'h0000_1000; xepc_r = '0;
        next_cycle();
        next_cycle();
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.insert_pc", 32'(insert_pc), 32'd0);
        check("reset.cause", cause, 32'd0);
        check("reset.drain_timeout", 32'(drain_timeout), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Exception, direct mode, pipeline already clear
        send(16'h0024, 32'h100, 32'hDEAD_BEEF, '0, 1'b0);
        next_cycle();
        check("exc.insert_pc", 32'(insert_pc), 32'd1);
        check("exc.priv_pc", priv_pc, 32'h0000_1000);
        check("exc.cause", cause, 32'd2);
        check("exc.epc", epc, 32'h100);
        check("exc.badaddr", badaddr, 32'hDEAD_BEEF);
        check("exc.trap_commit", 32'(trap_commit), 32'd1);
        next_cycle();

        // Vectored interrupt 7
        xtvec = 32'h8000_0001; mie = 1'b1; int_enable = 12'h080;
        send('0, 32'h200, 32'h1234, 12'h080, 1'b0);
        next_cycle();
        check("int.cause", cause, 32'h8000_0007);
        check("int.priv_pc", priv_pc, 32'h8000_001C);
        check("int.trap_commit", 32'(trap_commit), 32'd1);
        check("int.badaddr", badaddr, 32'd0);
        next_cycle();

        // Return: trap record untouched
        xepc_r = 32'h400;
        send('0, 32'h999, 32'h999, '0, 1'b1);
        next_cycle();
        check("ret.insert_pc", 32'(insert_pc), 32'd1);
        check("ret.priv_pc", priv_pc, 32'h400);
        check("ret.trap_commit", 32'(trap_commit), 32'd0);
        check("ret.cause", cause, 32'h8000_0007);
        check("ret.epc", epc, 32'h200);
        next_cycle();

        // Exception + mret + interrupt together: exception wins, mret dropped
        int_enable = 12'h001;
        send(16'h0001, 32'h300, 32'h44, 12'h001, 1'b1);
        next_cycle();
        check("combo.cause", cause, 32'd0);
        check("combo.trap_commit", 32'(trap_commit), 32'd1);
        check("combo.priv_pc", priv_pc, 32'h8000_0000);
        next_cycle();
        check("combo.no_return", 32'(busy), 32'd0);

        // Vectored wrap-around: base 0xFFFF_FFF0 + 4*5
        xtvec = 32'hFFFF_FFF1; int_enable = 12'h020;
        send('0, 32'h500, 32'h0, 12'h020, 1'b0);
        next_cycle();
        check("wrap.priv_pc", priv_pc, 32'h0000_0004);
        next_cycle();

        // Reserved mode 3 treated as direct
        xtvec = 32'h0000_2003; int_enable = 12'h008;
        send('0, 32'h600, 32'h0, 12'h008, 1'b0);
        next_cycle();
        check("mode3.priv_pc", priv_pc, 32'h0000_2000);
        check("mode3.cause", cause, 32'h8000_0003);
        next_cycle();

        // Interrupt masked by mie=0
        mie = 1'b0;
        send('0, 32'h700, 32'h0, 12'h008, 1'b0);
        next_cycle();
        check("masked.busy", 32'(busy), 32'd0);
        mie = 1'b1;

        // Drain timeout: redirect on the 17th cycle after the request
        pipe_clear = 1'b0;
        send(16'h0004, 32'h800, 32'h88, '0, 1'b0);
        repeat (15) next_cycle();
        check("tmo.c16_insert_pc", 32'(insert_pc), 32'd0);
        check("tmo.c16_busy", 32'(busy), 32'd1);
        next_cycle();
        check("tmo.c17_insert_pc", 32'(insert_pc), 32'd1);
        check("tmo.drain_timeout", 32'(drain_timeout), 32'd1);
        pipe_clear = 1'b1;
        send(16'h0008, 32'h900, 32'h0, '0, 1'b0);
        next_cycle();
        check("tmo.sticky", 32'(drain_timeout), 32'd1);
        check("tmo.cause3", cause, 32'd3);
        next_cycle();

        // Reset mid-drain
        pipe_clear = 1'b0;
        send(16'h0002, 32'hA00, 32'h0, '0, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.drain_timeout", 32'(drain_timeout), 32'd0);
        check("rst.cause", cause, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        pipe_clear = 1'b1;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            check("rst.no_insert", 32'(insert_pc), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
